uart_rx_bit_sampler: RTL and testbench

UART RX front-end stage sitting directly upstream of the deserializer.
- Synchronises RX_IN and runs the oversampling edge counter and the frame bit counter.
- Majority-votes three mid-bit samples to produce the sampled bit.
- Supplies Sampled_Bit and bit_count to the deserializer and the parity/stop checkers; frame control FSM drives cnt_en/samp_en.

---
 rtl/uart_rx_bit_sampler_if.sv | 27 ++
 rtl/uart_rx_bit_sampler.sv | 118 +++++++++++
 tb/tb_uart_rx_bit_sampler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_bit_sampler_if.sv
// Signal bundle between the UART RX frame controller and the bit sampler.
// The controller side uses the master modport; the sampler uses the slave modport.
interface uart_rx_bit_sampler_if #(
  parameter int EDGE_W = 6
);
  logic              RX_IN;
  logic [5:0]        Prescale;
  logic              PAR_EN;
  logic              cnt_en;
  logic              samp_en;
  logic              rx_sync;
  logic [EDGE_W-1:0] edge_cnt;
  logic [3:0]        bit_count;
  logic              Sampled_Bit;
  logic              sample_valid;
  logic              frame_done;

  modport master (
    output RX_IN, Prescale, PAR_EN, cnt_en, samp_en,
    input  rx_sync, edge_cnt, bit_count, Sampled_Bit, sample_valid, frame_done
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, cnt_en, samp_en,
    output rx_sync, edge_cnt, bit_count, Sampled_Bit, sample_valid, frame_done
  );
endinterface

// File: rtl/uart_rx_bit_sampler.sv
// UART RX front end: line synchroniser, oversample/bit counters and a
// three-sample majority vote around the middle of each bit.
module uart_rx_bit_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_W      = 6
) (
  input logic                  CLK,
  input logic                  RST,
  uart_rx_bit_sampler_if.slave bus
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   cnt_en_d_reg;
  logic [EDGE_W-1:0]      p_reg;
  logic [3:0]             last_bit_reg;
  logic [EDGE_W-1:0]      edge_cnt_reg, edge_cnt_next;
  logic [3:0]             bit_count_reg, bit_count_next;
  logic                   s0_reg, s0_next;
  logic                   s1_reg, s1_next;
  logic                   s2_reg, s2_next;
  logic                   arm_reg, arm_next;
  logic                   sbit_reg, sbit_next;
  logic                   valid_reg, valid_next;

  logic                   cnt_rise;
  logic [EDGE_W-1:0]      p_clamp, p_cur, half;
  logic [3:0]             last_bit_clamp, last_bit_cur;
  logic                   edge_last, bit_last, rx_s;

  assign rx_s     = sync_reg[SYNC_STAGES-1];
  assign cnt_rise = bus.cnt_en & ~cnt_en_d_reg;

  // On the rising cycle the fresh configuration is used directly so the
  // first frame sees the new ratio without waiting for the latch.
  assign p_clamp        = (bus.Prescale == 6'd16 || bus.Prescale == 6'd32) ?
                          EDGE_W'(bus.Prescale) : EDGE_W'(8);
  assign last_bit_clamp = bus.PAR_EN ? 4'd10 : 4'd9;
  assign p_cur          = cnt_rise ? p_clamp : p_reg;
  assign last_bit_cur   = cnt_rise ? last_bit_clamp : last_bit_reg;
  assign half           = p_cur >> 1;
  assign edge_last      = (edge_cnt_reg == p_cur - EDGE_W'(1));
  assign bit_last       = (bit_count_reg == last_bit_cur);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_reg      <= '1;
      cnt_en_d_reg  <= 1'b0;
      p_reg         <= EDGE_W'(8);
      last_bit_reg  <= 4'd10;
      edge_cnt_reg  <= '0;
      bit_count_reg <= '0;
      s0_reg        <= 1'b0;
      s1_reg        <= 1'b0;
      s2_reg        <= 1'b0;
      arm_reg       <= 1'b0;
      sbit_reg      <= 1'b1;
      valid_reg     <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], bus.RX_IN};
      cnt_en_d_reg  <= bus.cnt_en;
      if (cnt_rise) begin
        p_reg        <= p_clamp;
        last_bit_reg <= last_bit_clamp;
      end
      edge_cnt_reg  <= edge_cnt_next;
      bit_count_reg <= bit_count_next;
      s0_reg        <= s0_next;
      s1_reg        <= s1_next;
      s2_reg        <= s2_next;
      arm_reg       <= arm_next;
      sbit_reg      <= sbit_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    edge_cnt_next  = edge_cnt_reg;
    bit_count_next = bit_count_reg;
    s0_next        = s0_reg;
    s1_next        = s1_reg;
    s2_next        = s2_reg;
    arm_next       = arm_reg;
    sbit_next      = sbit_reg;
    valid_next     = 1'b0;
    if (!bus.cnt_en) begin
      edge_cnt_next  = '0;
      bit_count_next = '0;
      arm_next       = 1'b0;
    end else begin
      edge_cnt_next = edge_last ? '0 : edge_cnt_reg + EDGE_W'(1);
      if (edge_last)
        bit_count_next = bit_last ? 4'd0 : bit_count_reg + 4'd1;
      // arm_reg tracks that every sample of this bit was taken with samp_en high
      if (!bus.samp_en) begin
        arm_next = 1'b0;
      end else if (edge_cnt_reg == half - EDGE_W'(1)) begin
        s0_next  = rx_s;
        arm_next = 1'b1;
      end else if (edge_cnt_reg == half) begin
        s1_next = rx_s;
      end else if (edge_cnt_reg == half + EDGE_W'(1)) begin
        s2_next = rx_s;
      end else if (edge_cnt_reg == half + EDGE_W'(2)) begin
        if (arm_reg) begin
          sbit_next  = (s0_reg & s1_reg) | (s0_reg & s2_reg) | (s1_reg & s2_reg);
          valid_next = 1'b1;
        end
        arm_next = 1'b0;
      end
    end
  end

  assign bus.rx_sync      = rx_s;
  assign bus.edge_cnt     = edge_cnt_reg;
  assign bus.bit_count    = bit_count_reg;
  assign bus.Sampled_Bit  = sbit_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.frame_done   = bus.cnt_en & edge_last & bit_last;
endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: reset, full frames, vote glitches,
// prescale clamp/latch and vote abort, with hand-computed expectations.
module tb_uart_rx_bit_sampler;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_rx_bit_sampler_if #(.EDGE_W(6)) bus ();

  uart_rx_bit_sampler #(.SYNC_STAGES(2), .EDGE_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic       rx_w [0:511];
  logic       se_w [0:511];
  int         chg_cyc   = -1;
  logic [5:0] chg_pre   = 6'd8;
  int         probe_cyc = -1;
  logic       probe_val = 1'b0;
  int         sv_cyc [$];
  logic       sv_bit [$];
  int         fd_cnt;
  int         fd_cyc;
  logic       exp_bits [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_waves(input logic rx_val, input logic se_val);
    for (int i = 0; i < 512; i++) begin
      rx_w[i] = rx_val;
      se_w[i] = se_val;
    end
  endtask

  task automatic check_pulse(input string tag, input int idx, input int exp_cyc, input logic exp_bit);
    if (idx < sv_cyc.size()) begin
      check_eq({tag, ".cyc"}, sv_cyc[idx], exp_cyc);
      check_eq({tag, ".bit"}, int'(sv_bit[idx]), int'(exp_bit));
    end else begin
      check_eq({tag, ".missing"}, -1, exp_cyc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".rx_sync"}, int'(bus.rx_sync), 1);
    check_eq({tag, ".edge_cnt"}, int'(bus.edge_cnt), 0);
    check_eq({tag, ".bit_count"}, int'(bus.bit_count), 0);
    check_eq({tag, ".Sampled_Bit"}, int'(bus.Sampled_Bit), 1);
    check_eq({tag, ".sample_valid"}, int'(bus.sample_valid), 0);
    check_eq({tag, ".frame_done"}, int'(bus.frame_done), 0);
  endtask

  // Cycle c is the c-th cycle with cnt_en high; c == 0 is the rising cycle.
  task automatic run_frame(input int n, input int p_exp, input int l_exp, input string tag);
    sv_cyc.delete();
    sv_bit.delete();
    fd_cnt = 0;
    fd_cyc = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      #1;
      bus.cnt_en  = 1'b1;
      bus.samp_en = se_w[c];
      bus.RX_IN   = rx_w[c];
      if (c == chg_cyc) bus.Prescale = chg_pre;
      #1;
      check_eq({tag, ".edge_cnt"}, int'(bus.edge_cnt), c % p_exp);
      check_eq({tag, ".bit_count"}, int'(bus.bit_count), (c / p_exp) % l_exp);
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc = c;
      end
      if (bus.sample_valid) begin
        sv_cyc.push_back(c);
        sv_bit.push_back(bus.Sampled_Bit);
        $display("%s: sample_valid at cycle %0d Sampled_Bit=%0b", tag, c, bus.Sampled_Bit);
      end
      if (c == probe_cyc) probe_val = bus.Sampled_Bit;
    end
    @(posedge CLK);
    #1;
    bus.cnt_en  = 1'b0;
    bus.samp_en = 1'b0;
    bus.RX_IN   = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_eq({tag, ".idle_edge"}, int'(bus.edge_cnt), 0);
    check_eq({tag, ".idle_bit"}, int'(bus.bit_count), 0);
    check_eq({tag, ".idle_valid"}, int'(bus.sample_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RX_IN    = 1'b1;
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b1;
    bus.cnt_en   = 1'b0;
    bus.samp_en  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("por");
    RST = 1'b0;
    repeat (4) @(posedge CLK);

    // Asynchronous reset in the middle of bit 3, edge 5, with the line low.
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK);
      #1;
      bus.cnt_en  = 1'b1;
      bus.samp_en = 1'b1;
      bus.RX_IN   = 1'b0;
      #1;
    end
    check_eq("pre_rst.edge_cnt", int'(bus.edge_cnt), 5);
    check_eq("pre_rst.bit_count", int'(bus.bit_count), 3);
    check_eq("pre_rst.rx_sync", int'(bus.rx_sync), 0);
    check_eq("pre_rst.Sampled_Bit", int'(bus.Sampled_Bit), 0);
    #2;
    RST = 1'b1;
    #1;
    check_reset_state("async_rst");
    bus.cnt_en  = 1'b0;
    bus.samp_en = 1'b0;
    bus.RX_IN   = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);

    // P=8 with parity: start, 0xA5 LSB first, parity 0, stop 1.
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b1;
    set_waves(1'b1, 1'b1);
    for (int c = 0; c < 88; c++) rx_w[c] = exp_bits[c / 8];
    run_frame(88, 8, 11, "frame_p8");
    check_eq("frame_p8.pulses", sv_cyc.size(), 11);
    for (int i = 0; i < 11; i++) check_pulse($sformatf("frame_p8.s%0d", i), i, 8 * i + 7, exp_bits[i]);
    check_eq("frame_p8.fd_cnt", fd_cnt, 1);
    check_eq("frame_p8.fd_cyc", fd_cyc, 87);

    // P=16 line low: one glitched sample is outvoted, two win.
    bus.Prescale = 6'd16;
    set_waves(1'b0, 1'b1);
    rx_w[6]  = 1'b1;
    rx_w[21] = 1'b1;
    rx_w[22] = 1'b1;
    run_frame(32, 16, 11, "glitch_p16");
    check_eq("glitch_p16.pulses", sv_cyc.size(), 2);
    check_pulse("glitch_p16.single", 0, 11, 1'b0);
    check_pulse("glitch_p16.double", 1, 27, 1'b1);

    // Illegal 12 clamps to 8; a mid-frame change to 32 is ignored until re-rise.
    bus.Prescale = 6'd12;
    set_waves(1'b1, 1'b0);
    chg_cyc = 12;
    chg_pre = 6'd32;
    run_frame(24, 8, 11, "clamp12");
    check_eq("clamp12.pulses", sv_cyc.size(), 0);
    chg_cyc = -1;
    run_frame(40, 32, 11, "relatch32");
    check_eq("relatch32.pulses", sv_cyc.size(), 0);

    // No parity, P=32: ten bits, frame_done on the last edge only.
    bus.Prescale = 6'd32;
    bus.PAR_EN   = 1'b0;
    set_waves(1'b1, 1'b1);
    run_frame(320, 32, 10, "nopar_p32");
    check_eq("nopar_p32.fd_cnt", fd_cnt, 1);
    check_eq("nopar_p32.fd_cyc", fd_cyc, 319);
    check_eq("nopar_p32.pulses", sv_cyc.size(), 10);
    check_pulse("nopar_p32.first", 0, 19, 1'b1);
    check_pulse("nopar_p32.last", 9, 9 * 32 + 19, 1'b1);

    // samp_en dropped at edge P/2 of bit 0 aborts that vote only.
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b1;
    set_waves(1'b0, 1'b1);
    se_w[4]   = 1'b0;
    probe_cyc = 7;
    run_frame(16, 8, 11, "abort");
    check_eq("abort.pulses", sv_cyc.size(), 1);
    check_eq("abort.held_bit", int'(probe_val), 1);
    check_pulse("abort.next", 0, 15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
